// File: rtl/sim_cycle_monitor_if.sv
// Control and statistics bus between the cache-emulator run monitor and its tap/observer.
// The master side drives start/done/commands; the slave (monitor) returns counters and status.
interface sim_cycle_monitor_if #(
  parameter int N_CH  = 2,
  parameter int CMD_W = 3,
  parameter int CNT_W = 32
);
  logic                    start;
  logic                    done_in;
  logic [N_CH*CMD_W-1:0]   ch_cmd;
  logic [CNT_W-1:0]        clk_count;
  logic [N_CH*CNT_W-1:0]   txn_count;
  logic [N_CH*CNT_W-1:0]   busy_count;
  logic [1:0]              state;
  logic                    finished;
  logic                    timed_out;

  modport master (
    output start, done_in, ch_cmd,
    input  clk_count, txn_count, busy_count, state, finished, timed_out
  );

  modport slave (
    input  start, done_in, ch_cmd,
    output clk_count, txn_count, busy_count, state, finished, timed_out
  );
endinterface

// File: rtl/sim_cycle_monitor.sv
// Run controller and per-channel performance monitor for the cache emulator.
// Counts RUN cycles until done_in, or gives up after MAX_CLOCKS cycles.
module sim_cycle_monitor #(
  parameter int          N_CH       = 2,
  parameter int          CMD_W      = 3,
  parameter int          CNT_W      = 32,
  parameter int unsigned MAX_CLOCKS = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  sim_cycle_monitor_if.slave   mon
);
  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RUN     = 2'b01;
  localparam logic [1:0] S_DONE    = 2'b10;
  localparam logic [1:0] S_TIMEOUT = 2'b11;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CLOCKS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]                       state_q, state_d;
  logic [CNT_W-1:0]                 clk_cnt_q, clk_cnt_d;
  logic [N_CH-1:0][CNT_W-1:0]       txn_q, txn_d;
  logic [N_CH-1:0][CNT_W-1:0]       busy_q, busy_d;
  logic [N_CH-1:0][CMD_W-1:0]       prev_cmd_q, prev_cmd_d;
  logic                             finished_q, finished_d;
  logic                             timed_out_q, timed_out_d;
  logic [N_CH-1:0][CMD_W-1:0]       cmd;

  assign cmd = mon.ch_cmd;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    txn_d      = txn_q;
    busy_d     = busy_q;
    prev_cmd_d = cmd;
    case (state_q)
      S_RUN: begin
        if (mon.done_in) begin
          state_d = S_DONE;
        end else if (clk_cnt_q == MAX_CNT) begin
          state_d = S_TIMEOUT;
        end else begin
          clk_cnt_d = clk_cnt_q + ONE;
          for (int i = 0; i < N_CH; i++) begin
            if (cmd[i] != '0) begin
              busy_d[i] = busy_q[i] + ONE;
              // only an idle-to-active edge opens a new transaction
              if (prev_cmd_q[i] == '0) txn_d[i] = txn_q[i] + ONE;
            end
          end
        end
      end
      default: begin
        if (mon.start) begin
          state_d   = S_RUN;
          clk_cnt_d = '0;
          txn_d     = '0;
          busy_d    = '0;
        end
      end
    endcase
    finished_d  = (state_d == S_DONE);
    timed_out_d = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      txn_q       <= '0;
      busy_q      <= '0;
      prev_cmd_q  <= '0;
      finished_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      txn_q       <= txn_d;
      busy_q      <= busy_d;
      prev_cmd_q  <= prev_cmd_d;
      finished_q  <= finished_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign mon.clk_count  = clk_cnt_q;
  assign mon.txn_count  = txn_q;
  assign mon.busy_count = busy_q;
  assign mon.state      = state_q;
  assign mon.finished   = finished_q;
  assign mon.timed_out  = timed_out_q;
endmodule

// File: tb/tb_sim_cycle_monitor.sv
// Self-checking bench for sim_cycle_monitor: directed scenarios plus randomized runs
// compared against a run-level reference model that replays the command sequence.
module tb_sim_cycle_monitor;
  localparam int N_CH  = 2;
  localparam int CMD_W = 3;
  localparam int CNT_W = 32;
  localparam int MAXC  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sim_cycle_monitor_if #(.N_CH(N_CH), .CMD_W(CMD_W), .CNT_W(CNT_W)) bus ();

  sim_cycle_monitor #(
    .N_CH(N_CH), .CMD_W(CMD_W), .CNT_W(CNT_W), .MAX_CLOCKS(MAXC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  bit [N_CH*CMD_W-1:0] seq_cmd   [0:63];
  bit                  seq_done  [0:63];
  bit                  seq_start [0:63];
  int                  seq_len;

  int         exp_clk;
  logic [1:0] exp_state;
  int         exp_txn  [N_CH];
  int         exp_busy [N_CH];
  int         end_k;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seq();
    for (int k = 0; k < 64; k++) begin
      seq_cmd[k] = '0; seq_done[k] = 1'b0; seq_start[k] = 1'b0;
    end
    seq_len = 0;
  endtask

  // Replays the sequence with the run rules: stop on done, stop at the limit, else count.
  task automatic model_run(input bit [N_CH*CMD_W-1:0] c0);
    bit [N_CH*CMD_W-1:0] prev;
    bit [CMD_W-1:0] cur, pc;
    prev = c0;
    exp_clk = 0; exp_state = 2'b01; end_k = seq_len - 1;
    for (int i = 0; i < N_CH; i++) begin exp_txn[i] = 0; exp_busy[i] = 0; end
    for (int k = 0; k < seq_len; k++) begin
      if (seq_done[k]) begin exp_state = 2'b10; end_k = k; break; end
      if (exp_clk == MAXC) begin exp_state = 2'b11; end_k = k; break; end
      exp_clk++;
      for (int i = 0; i < N_CH; i++) begin
        cur = seq_cmd[k][i*CMD_W +: CMD_W];
        pc  = prev[i*CMD_W +: CMD_W];
        if (cur != 0) begin
          exp_busy[i]++;
          if (pc == 0) exp_txn[i]++;
        end
      end
      prev = seq_cmd[k];
    end
  endtask

  task automatic drive_run(input bit [N_CH*CMD_W-1:0] c0);
    model_run(c0);
    bus.start = 1'b1; bus.ch_cmd = c0; bus.done_in = 1'b0;
    tick();
    for (int k = 0; k <= end_k; k++) begin
      bus.start = seq_start[k]; bus.ch_cmd = seq_cmd[k]; bus.done_in = seq_done[k];
      tick();
    end
    bus.start = 1'b0; bus.ch_cmd = '0; bus.done_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.done_in = 1'b0; bus.ch_cmd = '0;
    tick(); tick();
    n_checks++;
    if (bus.state !== 2'b00 || bus.clk_count !== '0 || bus.txn_count !== '0 ||
        bus.busy_count !== '0 || bus.finished !== 1'b0 || bus.timed_out !== 1'b0) begin
      n_errs++;
      $display("FAIL reset: state=%b clk=%0d txn=%h busy=%h fin=%b to=%b, required all zero",
               bus.state, bus.clk_count, bus.txn_count, bus.busy_count, bus.finished, bus.timed_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_done_after_10();
    clear_seq(); seq_len = 11; seq_done[10] = 1'b1;
    drive_run('0);
    n_checks++;
    if (bus.clk_count !== 32'd10 || bus.state !== 2'b10 || bus.finished !== 1'b1 || bus.timed_out !== 1'b0) begin
      n_errs++;
      $display("FAIL done10: clk=%0d state=%b fin=%b to=%b, required clk=10 state=10 fin=1 to=0",
               bus.clk_count, bus.state, bus.finished, bus.timed_out);
    end
    for (int c = 0; c < 20; c++) begin
      bus.ch_cmd = 6'(c); bus.done_in = c[0];
      tick();
    end
    bus.ch_cmd = '0; bus.done_in = 1'b0;
    n_checks++;
    if (bus.clk_count !== 32'd10 || bus.state !== 2'b10 || bus.finished !== 1'b1 ||
        bus.txn_count !== '0 || bus.busy_count !== '0) begin
      n_errs++;
      $display("FAIL done10_hold: clk=%0d state=%b fin=%b txn=%h busy=%h, required clk=10 state=10 fin=1 zero counts",
               bus.clk_count, bus.state, bus.finished, bus.txn_count, bus.busy_count);
    end
  endtask

  task automatic test_timeout();
    clear_seq(); seq_len = 20;
    drive_run('0);
    n_checks++;
    if (bus.clk_count !== 32'(MAXC) || bus.state !== 2'b11 || bus.timed_out !== 1'b1 || bus.finished !== 1'b0) begin
      n_errs++;
      $display("FAIL timeout: clk=%0d state=%b to=%b fin=%b, required clk=%0d state=11 to=1 fin=0",
               bus.clk_count, bus.state, bus.timed_out, bus.finished, MAXC);
    end
    bus.done_in = 1'b1; tick(); tick(); tick(); bus.done_in = 1'b0;
    n_checks++;
    if (bus.state !== 2'b11 || bus.timed_out !== 1'b1 || bus.clk_count !== 32'(MAXC)) begin
      n_errs++;
      $display("FAIL timeout_done_ignored: state=%b to=%b clk=%0d, required state=11 to=1 clk=%0d",
               bus.state, bus.timed_out, bus.clk_count, MAXC);
    end
  endtask

  task automatic test_txn_pattern();
    int c0s [7] = '{0, 1, 1, 0, 2, 3, 0};
    int c1s [7] = '{0, 0, 1, 0, 1, 0, 0};
    int r_txn [2] = '{2, 2};
    int r_busy[2] = '{4, 2};
    clear_seq(); seq_len = 8; seq_done[7] = 1'b1;
    for (int k = 0; k < 7; k++) seq_cmd[k] = {3'(c1s[k]), 3'(c0s[k])};
    drive_run('0);
    n_checks++;
    if (bus.clk_count !== 32'd7 || bus.state !== 2'b10) begin
      n_errs++;
      $display("FAIL pattern_clk: clk=%0d state=%b, required clk=7 state=10", bus.clk_count, bus.state);
    end
    for (int i = 0; i < N_CH; i++) begin
      n_checks++;
      if (bus.txn_count[i*CNT_W +: CNT_W] !== 32'(r_txn[i]) || bus.busy_count[i*CNT_W +: CNT_W] !== 32'(r_busy[i])) begin
        n_errs++;
        $display("FAIL pattern_ch%0d: txn=%0d busy=%0d, required txn=%0d busy=%0d", i,
                 bus.txn_count[i*CNT_W +: CNT_W], bus.busy_count[i*CNT_W +: CNT_W], r_txn[i], r_busy[i]);
      end
    end
  endtask

  task automatic test_start_edge_cmd();
    clear_seq(); seq_len = 5;
    seq_cmd[0] = 6'd1; seq_cmd[1] = 6'd1; seq_cmd[2] = 6'd1; seq_done[4] = 1'b1;
    drive_run(6'd1);
    n_checks++;
    if (bus.txn_count[0 +: CNT_W] !== 32'd0 || bus.busy_count[0 +: CNT_W] !== 32'd3 || bus.clk_count !== 32'd4) begin
      n_errs++;
      $display("FAIL start_edge_cmd: txn0=%0d busy0=%0d clk=%0d, required txn0=0 busy0=3 clk=4",
               bus.txn_count[0 +: CNT_W], bus.busy_count[0 +: CNT_W], bus.clk_count);
    end
  endtask

  task automatic test_done_and_timeout();
    clear_seq(); seq_len = MAXC + 1; seq_done[MAXC] = 1'b1;
    drive_run('0);
    n_checks++;
    if (bus.state !== 2'b10 || bus.finished !== 1'b1 || bus.timed_out !== 1'b0 || bus.clk_count !== 32'(MAXC)) begin
      n_errs++;
      $display("FAIL done_beats_timeout: state=%b fin=%b to=%b clk=%0d, required state=10 fin=1 to=0 clk=%0d",
               bus.state, bus.finished, bus.timed_out, bus.clk_count, MAXC);
    end
    clear_seq(); seq_len = 1; seq_done[0] = 1'b1;
    drive_run(6'd9);
    n_checks++;
    if (bus.state !== 2'b10 || bus.clk_count !== 32'd0 || bus.busy_count !== '0) begin
      n_errs++;
      $display("FAIL immediate_done: state=%b clk=%0d busy=%h, required state=10 clk=0 busy=0",
               bus.state, bus.clk_count, bus.busy_count);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1; bus.ch_cmd = '0; tick(); bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin bus.ch_cmd = 6'(k * 9 + 1); tick(); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if (bus.state !== 2'b00 || bus.clk_count !== '0 || bus.txn_count !== '0 || bus.busy_count !== '0) begin
      n_errs++;
      $display("FAIL reset_mid_run: state=%b clk=%0d txn=%h busy=%h, required idle and zero",
               bus.state, bus.clk_count, bus.txn_count, bus.busy_count);
    end
    clear_seq(); seq_len = 4; seq_cmd[0] = 6'o12; seq_cmd[1] = 6'o34; seq_done[3] = 1'b1;
    drive_run('0);
    bus.start = 1'b1; bus.ch_cmd = 6'o77; tick(); bus.start = 1'b0;
    n_checks++;
    if (bus.state !== 2'b01 || bus.finished !== 1'b0 || bus.clk_count !== '0 ||
        bus.txn_count !== '0 || bus.busy_count !== '0) begin
      n_errs++;
      $display("FAIL restart_from_done: state=%b fin=%b clk=%0d txn=%h busy=%h, required state=01 fin=0 zero counts",
               bus.state, bus.finished, bus.clk_count, bus.txn_count, bus.busy_count);
    end
    bus.done_in = 1'b1; tick(); bus.done_in = 1'b0; bus.ch_cmd = '0; tick();
  endtask

  task automatic test_random_runs();
    bit [N_CH*CMD_W-1:0] c0;
    for (int r = 0; r < 30; r++) begin
      clear_seq();
      seq_len = int'($urandom_range(1, 24));
      for (int k = 0; k < seq_len; k++) begin
        for (int i = 0; i < N_CH; i++)
          seq_cmd[k][i*CMD_W +: CMD_W] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        seq_done[k]  = ($urandom_range(0, 9) == 0);
        seq_start[k] = ($urandom_range(0, 5) == 0);
      end
      seq_done[seq_len-1] = 1'b1;
      c0 = 6'($urandom);
      drive_run(c0);
      n_checks++;
      if (bus.state !== exp_state || bus.clk_count !== 32'(exp_clk) ||
          bus.finished !== (exp_state == 2'b10) || bus.timed_out !== (exp_state == 2'b11)) begin
        n_errs++;
        $display("FAIL random_run%0d: state=%b clk=%0d fin=%b to=%b, required state=%b clk=%0d",
                 r, bus.state, bus.clk_count, bus.finished, bus.timed_out, exp_state, exp_clk);
      end
      for (int i = 0; i < N_CH; i++) begin
        n_checks++;
        if (bus.txn_count[i*CNT_W +: CNT_W] !== 32'(exp_txn[i]) || bus.busy_count[i*CNT_W +: CNT_W] !== 32'(exp_busy[i])) begin
          n_errs++;
          $display("FAIL random_run%0d_ch%0d: txn=%0d busy=%0d, required txn=%0d busy=%0d", r, i,
                   bus.txn_count[i*CNT_W +: CNT_W], bus.busy_count[i*CNT_W +: CNT_W], exp_txn[i], exp_busy[i]);
        end
      end
      for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
        bus.ch_cmd = 6'($urandom); bus.done_in = 1'($urandom);
        tick();
      end
      bus.ch_cmd = '0; bus.done_in = 1'b0;
      n_checks++;
      if (bus.clk_count !== 32'(exp_clk) || bus.state !== exp_state) begin
        n_errs++;
        $display("FAIL random_hold%0d: clk=%0d state=%b, required clk=%0d state=%b",
                 r, bus.clk_count, bus.state, exp_clk, exp_state);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.done_in = 1'b0; bus.ch_cmd = '0;
    test_reset();
    test_done_after_10();
    test_timeout();
    test_txn_pattern();
    test_start_edge_cmd();
    test_done_and_timeout();
    test_reset_mid_run();
    test_random_runs();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/sim_cycle_monitor.md
Name: sim_cycle_monitor

Overview:
- Synthesizable run controller and performance monitor for the cache emulator.
- Counts clocks from a start pulse until the CPU reports done, and aborts with a timeout flag after MAX_CLOCKS cycles.
- Also counts, per command channel, new transactions and busy cycles, for example the CPU-cache bus and the cache-memory bus.
- Sits beside the memory, cache and CPU instances and taps their control buses passively.

Parameters:
N_CH, 2, number of monitored command channels (1..8)
CMD_W, 3, width of each channel command field; narrower buses are zero-extended by the instantiator
CNT_W, 32, width of every counter
MAX_CLOCKS, 100000000, timeout limit in RUN cycles; must satisfy 1 <= MAX_CLOCKS <= 2^CNT_W - 1

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: clear counters and begin a run
done_in  input  1  CPU finished indication (level)
ch_cmd  input  N_CH*CMD_W  channel i command at bits [i*CMD_W +: CMD_W]; 0 = NOP
clk_count  output  CNT_W  RUN cycles counted
txn_count  output  N_CH*CNT_W  per-channel new-transaction count, same slicing with CNT_W
busy_count  output  N_CH*CNT_W  per-channel cycles with non-NOP command
state  output  2  00 IDLE, 01 RUN, 10 DONE, 11 TIMEOUT
finished  output  1  high in DONE
timed_out  output  1  high in TIMEOUT

Behaviour:
- Reset, sampled on the clk edge: state=IDLE; all counters 0; all prev_cmd registers 0; finished=0; timed_out=0. Reset in any state, including mid-RUN, overrides every other input.
- prev_cmd[i] is a register that captures ch_cmd slice i every cycle in all states.
- IDLE: counters hold. start=1 -> next state RUN, and all counters clear to 0 on that same edge.
- RUN: evaluate each cycle in this priority order:
  - done_in=1 -> next state DONE. This cycle adds nothing to any counter.
  - else if clk_count == MAX_CLOCKS -> next state TIMEOUT. Nothing is added.
  - else clk_count += 1. For each channel i:
    - ch_cmd[i] != 0 -> busy_count[i] += 1.
    - ch_cmd[i] != 0 and prev_cmd[i] == 0 -> txn_count[i] += 1.
    - A non-NOP to different non-NOP change is not a new transaction.
- RUN, other rules:
  - start is ignored.
  - done_in and timeout condition together -> DONE wins.
  - If done_in is already 1 on the first RUN cycle, the run ends with clk_count=0.
  - A command that is active on the start edge has prev_cmd = that command in the first RUN cycle, so it is not counted as a new transaction. It is counted as busy.
- DONE / TIMEOUT:
  - All counters hold.
  - finished or timed_out is high, registered, asserted from the first cycle in the state.
  - start=1 -> RUN with counters cleared, flags drop on the same edge.
  - done_in is ignored.
- Counter limits: clk_count never exceeds MAX_CLOCKS, and busy_count and txn_count <= clk_count, so no saturation logic is required. Wrap is impossible by the parameter constraint.
- All outputs are registered, with no combinational path from inputs to outputs. Counts are visible the cycle after the counting edge.

Test Plan:
- Reset then start pulse, done_in raised after 10 RUN cycles -> clk_count=10, state=10, finished=1, timed_out=0; values hold 20 further cycles.
- MAX_CLOCKS=16, start, done_in held 0 -> clk_count=16, state=11, timed_out=1; subsequent done_in=1 leaves state at 11.
- N_CH=2, in RUN, ch0 sequence 0,1,1,0,2,3,0 and ch1 sequence 0,0,1,0,1,0,0 -> txn_count[0]=2, busy_count[0]=4, txn_count[1]=2, busy_count[1]=2, clk_count=7.
- ch0=1 held across the start edge for 3 RUN cycles then 0 -> txn_count[0]=0, busy_count[0]=3.
- Same cycle done_in=1 and clk_count==MAX_CLOCKS -> state=10, finished=1, timed_out=0.
- Reset asserted at RUN cycle 5 -> next cycle state=00, all counters 0. Then start in DONE -> counters cleared, finished=0, state=01.
